// File: rtl/adc_capture_ctrl.sv
// Single-channel scope capture: pre-trigger history + post-trigger samples in a circular
// buffer, hysteretic edge trigger, oldest-first readout. ADC_CAP_AUTO_TRIG_EN adds auto-trigger.
module adc_capture_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int TO_W   = 24
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] AD_Data,
  input  logic              Smp_En,
  input  logic              Arm,
  input  logic [DATA_W-1:0] Trig_Level,
  input  logic [DATA_W-1:0] Trig_Hyst,
  input  logic              Trig_Edge,
  input  logic              Force_Trig,
  input  logic [ADDR_W-1:0] Pre_Len,
  input  logic [TO_W-1:0]   Auto_Timeout,
  input  logic              Rd_En,
  output logic [DATA_W-1:0] Rd_Data,
  output logic              Rd_Valid,
  output logic              Busy,
  output logic              Done,
  output logic              Auto_Trig
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, READ} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp, rp, t_addr, pre_len, cnt, rd_addr, post_last;
  logic              armed, force_pend, rd_pend;
  logic              smp_wr, arm_hit, lvl_hit, auto_hit, trig, auto_only;
  logic [DATA_W-1:0] lo_thr, hi_thr;
  logic [DATA_W:0]   hi_sum;

  // Thresholds saturate rather than wrap so extreme level/hysteresis pairs stay sane.
  always_comb begin
    smp_wr    = Smp_En && (state == PRE || state == WAIT_TRIG || state == POST);
    lo_thr    = (Trig_Level > Trig_Hyst) ? Trig_Level - Trig_Hyst : '0;
    hi_sum    = {1'b0, Trig_Level} + {1'b0, Trig_Hyst};
    hi_thr    = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];
    arm_hit   = Trig_Edge ? (AD_Data > hi_thr) : (AD_Data < lo_thr);
    lvl_hit   = Trig_Edge ? (AD_Data <= Trig_Level) : (AD_Data >= Trig_Level);
    trig      = Smp_En && (Force_Trig || force_pend || (armed && lvl_hit) || auto_hit);
    auto_only = auto_hit && !(Force_Trig || force_pend || (armed && lvl_hit));
    post_last = ~pre_len - ADDR_W'(1);
  end

`ifdef ADC_CAP_AUTO_TRIG_EN
  logic [TO_W-1:0] to_cnt;

  assign auto_hit = (Auto_Timeout != '0) && (to_cnt >= Auto_Timeout);

  always_ff @(posedge Clk or posedge Reset)
    if (Reset)                         to_cnt <= '0;
    else if (state != WAIT_TRIG)       to_cnt <= '0;
    else if (Smp_En && !auto_hit && !(&to_cnt)) to_cnt <= to_cnt + TO_W'(1);
`else
  logic unused_to;

  assign auto_hit  = 1'b0;
  assign unused_to = ^Auto_Timeout;
`endif

  always_ff @(posedge Clk)
    if (smp_wr) mem[wp] <= AD_Data;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      Rd_Data    <= '0;
      Rd_Valid   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Auto_Trig  <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      t_addr     <= '0;
      pre_len    <= '0;
      cnt        <= '0;
      rd_addr    <= '0;
      armed      <= 1'b0;
      force_pend <= 1'b0;
      rd_pend    <= 1'b0;
    end else begin
      // Read data lags the accepting edge by one cycle (registered RAM output).
      Rd_Valid <= rd_pend;
      if (rd_pend) Rd_Data <= mem[rd_addr];
      rd_pend <= 1'b0;
      if (smp_wr) wp <= wp + ADDR_W'(1);

      if ((state == IDLE || state == READ) && Arm) begin
        state      <= (Pre_Len == '0) ? WAIT_TRIG : PRE;
        pre_len    <= Pre_Len;
        wp         <= '0;
        cnt        <= '0;
        armed      <= 1'b0;
        force_pend <= 1'b0;
        Auto_Trig  <= 1'b0;
        Busy       <= 1'b1;
        Done       <= 1'b0;
      end else begin
        case (state)
          PRE: if (Smp_En) begin
            cnt <= cnt + ADDR_W'(1);
            if (cnt == pre_len - ADDR_W'(1)) begin
              state      <= WAIT_TRIG;
              armed      <= 1'b0;
              force_pend <= 1'b0;
            end
          end
          WAIT_TRIG: begin
            if (Force_Trig && !Smp_En) force_pend <= 1'b1;
            if (trig) begin
              t_addr     <= wp;
              cnt        <= '0;
              force_pend <= 1'b0;
              Auto_Trig  <= auto_only;
              if (&pre_len) begin
                state <= READ;
                Busy  <= 1'b0;
                Done  <= 1'b1;
                rp    <= wp + ADDR_W'(1);
              end else begin
                state <= POST;
              end
            end else if (Smp_En && arm_hit) begin
              armed <= 1'b1;
            end
          end
          POST: if (Smp_En) begin
            cnt <= cnt + ADDR_W'(1);
            if (cnt == post_last) begin
              state <= READ;
              Busy  <= 1'b0;
              Done  <= 1'b1;
              rp    <= t_addr - pre_len;
              cnt   <= '0;
            end
          end
          READ: if (Rd_En) begin
            rd_addr <= rp;
            rd_pend <= 1'b1;
            rp      <= rp + ADDR_W'(1);
            cnt     <= cnt + ADDR_W'(1);
            if (&cnt) begin
              state <= IDLE;
              Done  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with DATA_W=8, ADDR_W=4 (16-sample buffer).
module tb_adc_capture_ctrl;
  localparam int DATA_W = 8, ADDR_W = 4, TO_W = 24;

  logic              Clk, Reset, Smp_En, Arm, Trig_Edge, Force_Trig, Rd_En;
  logic [DATA_W-1:0] AD_Data, Trig_Level, Trig_Hyst, Rd_Data;
  logic [ADDR_W-1:0] Pre_Len;
  logic [TO_W-1:0]   Auto_Timeout;
  logic              Rd_Valid, Busy, Done, Auto_Trig;

  int n_pass = 0, n_fail = 0, n_tot = 0;
  logic [7:0] stim   [64];
  logic [7:0] exp_rd [16];

  adc_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TO_W(TO_W)) dut (
    .Clk(Clk), .Reset(Reset), .AD_Data(AD_Data), .Smp_En(Smp_En), .Arm(Arm),
    .Trig_Level(Trig_Level), .Trig_Hyst(Trig_Hyst), .Trig_Edge(Trig_Edge),
    .Force_Trig(Force_Trig), .Pre_Len(Pre_Len), .Auto_Timeout(Auto_Timeout),
    .Rd_En(Rd_En), .Rd_Data(Rd_Data), .Rd_Valid(Rd_Valid), .Busy(Busy),
    .Done(Done), .Auto_Trig(Auto_Trig)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic arm_cap(input logic [ADDR_W-1:0] pl);
    Pre_Len = pl; Arm = 1'b1; Smp_En = 1'b0;
    tick();
    Arm = 1'b0;
    chk("arm_busy", Busy, 1'b1);
  endtask

  // Feed n qualified samples from stim[], one every 'period' cycles; junk on idle cycles.
  task automatic feed(input int n, input int period, input string tag);
    int first = -1;
    for (int k = 0; k < n; k++)
      for (int p = 0; p < period; p++) begin
        Smp_En  = (p == 0);
        AD_Data = (p == 0) ? stim[k] : 8'hFF;
        tick();
        if (Done && first < 0) first = k * period + p;
      end
    Smp_En = 1'b0;
    chk(tag, first, (n - 1) * period);
    chk({tag, "_busy"}, Busy, 1'b0);
  endtask

  task automatic read_all(input string tag);
    Rd_En = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (i == 14) chk({tag, "_done_hold"}, Done, 1'b1);
      if (i == 15) begin
        Rd_En = 1'b0;
        chk({tag, "_done_fall"}, Done, 1'b0);
      end
      if (i >= 1) begin
        chk({tag, "_vld"}, Rd_Valid, 1'b1);
        chk($sformatf("%s_rd%0d", tag, i - 1), Rd_Data, exp_rd[i-1]);
      end
    end
    tick();
    chk({tag, "_vld_end"}, Rd_Valid, 1'b0);
  endtask

  initial begin
    Reset = 1'b1; AD_Data = '0; Smp_En = 0; Arm = 0; Trig_Level = 8'h80; Trig_Hyst = 8'h10;
    Trig_Edge = 0; Force_Trig = 0; Pre_Len = '0; Auto_Timeout = '0; Rd_En = 0;
    tick(); tick();
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_vld", Rd_Valid, 1'b0);
    chk("rst_data", Rd_Data, 8'h00);
    chk("rst_auto", Auto_Trig, 1'b0);
    Reset = 1'b0;
    tick();

    // Rising ramp, Pre_Len=4: trigger at 0x80, readout 0x7C..0x8B.
    for (int i = 0; i < 44; i++) stim[i] = 8'(8'h60 + i);
    for (int i = 0; i < 16; i++) exp_rd[i] = 8'(8'h7C + i);
    arm_cap(4'd4);
    feed(44, 1, "rise_done");
    read_all("rise");

    Rd_En = 1'b1; tick(); Rd_En = 1'b0;
    chk("idle_rd_ign0", Rd_Valid, 1'b0);
    tick();
    chk("idle_rd_ign1", Rd_Valid, 1'b0);

    // Asynchronous reset mid-POST.
    arm_cap(4'd0);
    Force_Trig = 1'b1; Smp_En = 1'b1; AD_Data = 8'h66; tick();
    Force_Trig = 1'b0; AD_Data = 8'h67; tick(); tick(); Smp_En = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("post_rst_busy", Busy, 1'b0);
    chk("post_rst_done", Done, 1'b0);
    chk("post_rst_data", Rd_Data, 8'h00);
    chk("post_rst_vld", Rd_Valid, 1'b0);
    tick(); Reset = 1'b0; tick();

    // Falling edge: dip to 0x78 right after entry must not fire; fires at 0x7F after 0x95.
    Trig_Edge = 1'b1;
    stim[0] = 8'hA0; stim[1] = 8'hA0; stim[2] = 8'h85; stim[3] = 8'h78; stim[4] = 8'h85;
    stim[5] = 8'h95; stim[6] = 8'h88; stim[7] = 8'h81; stim[8] = 8'h7F;
    for (int i = 0; i < 13; i++) stim[9+i] = 8'(8'h10 + i);
    exp_rd[0] = 8'h88; exp_rd[1] = 8'h81; exp_rd[2] = 8'h7F;
    for (int i = 0; i < 13; i++) exp_rd[3+i] = 8'(8'h10 + i);
    arm_cap(4'd2);
    feed(22, 1, "fall_done");
    read_all("fall");
    Trig_Edge = 1'b0;

    // Smp_En every third cycle, Pre_Len=0.
    stim[0] = 8'h20; stim[1] = 8'h90;
    for (int i = 0; i < 15; i++) stim[2+i] = 8'(i);
    exp_rd[0] = 8'h90;
    for (int i = 0; i < 15; i++) exp_rd[1+i] = 8'(i);
    arm_cap(4'd0);
    feed(17, 3, "dec_done");
    read_all("dec");

    // Force_Trig on an unqualified cycle defers to the next qualified sample.
    arm_cap(4'd0);
    Smp_En = 1'b1; AD_Data = 8'h40; tick(); tick(); tick();
    Force_Trig = 1'b1; Smp_En = 1'b0; AD_Data = 8'h41; tick();
    Force_Trig = 1'b0;
    stim[0] = 8'h42;
    for (int i = 1; i < 16; i++) stim[i] = 8'h40;
    exp_rd[0] = 8'h42;
    for (int i = 1; i < 16; i++) exp_rd[i] = 8'h40;
    feed(16, 1, "force_done");
    read_all("force");

    // Auto-trigger after 5 qualified WAIT_TRIG samples.
    Auto_Timeout = 24'd5;
    arm_cap(4'd0);
`ifdef ADC_CAP_AUTO_TRIG_EN
    for (int i = 0; i < 21; i++) stim[i] = 8'(8'h30 + i);
    for (int i = 0; i < 16; i++) exp_rd[i] = 8'(8'h35 + i);
    feed(21, 1, "auto_done");
    chk("auto_flag", Auto_Trig, 1'b1);
    read_all("auto");
`else
    Smp_En = 1'b1; AD_Data = 8'h30;
    repeat (40) tick();
    Smp_En = 1'b0;
    chk("noauto_busy", Busy, 1'b1);
    chk("noauto_done", Done, 1'b0);
    chk("noauto_flag", Auto_Trig, 1'b0);
    Reset = 1'b1; tick(); Reset = 1'b0; tick();
`endif
    Auto_Timeout = '0;

    // Arm during READ abandons readout and restarts capture.
    arm_cap(4'd0);
    Force_Trig = 1'b1; Smp_En = 1'b1; AD_Data = 8'h55; tick();
    Force_Trig = 1'b0;
    for (int i = 0; i < 15; i++) stim[i] = 8'h56;
    feed(15, 1, "rearm_done");
    Rd_En = 1'b1; tick(); tick();
    chk("rearm_rd0", Rd_Data, 8'h55);
    chk("rearm_vld0", Rd_Valid, 1'b1);
    Rd_En = 1'b0; Arm = 1'b1; Pre_Len = 4'd3; tick(); Arm = 1'b0;
    chk("rearm_done_clr", Done, 1'b0);
    chk("rearm_busy", Busy, 1'b1);
    #2 Reset = 1'b1;
    #1;
    chk("rearm_rst_busy", Busy, 1'b0);
    tick(); Reset = 1'b0; tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
